// File: rtl/motion_sequencer.sv
// =============================================================================
// motion_sequencer
// -----------------------------------------------------------------------------
// Sits between the TMR-voted speed/direction commands and the motor driver.
// Ramps the applied speed toward the commanded speed one unit per ramp period,
// brakes to zero before any direction reversal, forces an emergency stop when
// every TMR lane is flagged faulty, and generates the drive PWM from the
// applied speed.
//
// Optional build macro: MOTION_SEQ_DWELL_EN
//   defined   : after braking to zero the sequencer waits dwell_t cycles at
//               zero speed (DWELL state) before latching the new direction.
//   undefined : no DWELL state and no dwell counter; the new direction is
//               latched on the same edge that braking reaches zero.
//
// Parameters
//   cmd_l        width of the speed/direction commands
//   def_dir_cmd  direction applied after reset
//   ramp_t       clock cycles per one-unit speed step (>= 2)
//   dwell_t      clock cycles held at zero before a reversal (>= 1)
//   pwm_div      clock cycles per PWM counter increment (>= 1)
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   speed_cmd_i  voted speed command (0 = stop)
//   dir_cmd_i    voted direction command
//   fault        per-lane TMR fault flags, 3'b111 = no trustworthy lane
//   speed_o      currently applied speed
//   dir_o        currently applied direction
//   pwm_o        drive PWM, duty = speed_o / 2^cmd_l
//   moving       high when speed_o != 0
//   state_o      FSM state code (IDLE=0 RUN=1 BRAKE=2 DWELL=3 ESTOP=4)
// =============================================================================
module motion_sequencer #(
    parameter int cmd_l       = 4,
    parameter int def_dir_cmd = 8,
    parameter int ramp_t      = 500_000,
    parameter int dwell_t     = 2_500_000,
    parameter int pwm_div     = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [cmd_l-1:0] speed_cmd_i,
    input  logic [cmd_l-1:0] dir_cmd_i,
    input  logic [2:0]       fault,
    output logic [cmd_l-1:0] speed_o,
    output logic [cmd_l-1:0] dir_o,
    output logic             pwm_o,
    output logic             moving,
    output logic [2:0]       state_o
);

`ifdef MOTION_SEQ_DWELL_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_BRAKE = 3'd2,
        ST_DWELL = 3'd3,
        ST_ESTOP = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_BRAKE = 3'd2,
        ST_ESTOP = 3'd4
    } state_t;
`endif

    localparam int RAMP_W = (ramp_t > 1) ? $clog2(ramp_t) : 1;
    localparam int PRE_W  = (pwm_div > 1) ? $clog2(pwm_div) : 1;
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(ramp_t - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(pwm_div - 1);
    localparam logic [cmd_l-1:0]  DEF_DIR   = cmd_l'(def_dir_cmd);

`ifdef MOTION_SEQ_DWELL_EN
    localparam int DWELL_W = (dwell_t > 1) ? $clog2(dwell_t) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(dwell_t - 1);
`endif

    // One +/-1 step toward the target, saturating at the target.
    function automatic logic [cmd_l-1:0] step_toward(input logic [cmd_l-1:0] cur,
                                                     input logic [cmd_l-1:0] target);
        if (cur < target)
            step_toward = cur + 1'b1;
        else if (cur > target)
            step_toward = cur - 1'b1;
        else
            step_toward = cur;
    endfunction

    // Decrement that saturates at zero.
    function automatic logic [cmd_l-1:0] dec_sat(input logic [cmd_l-1:0] cur);
        if (cur == '0)
            dec_sat = '0;
        else
            dec_sat = cur - 1'b1;
    endfunction

    state_t             state_q;
    state_t             state_d;
    logic [cmd_l-1:0]   speed_d;
    logic [cmd_l-1:0]   dir_d;
    logic [RAMP_W-1:0]  ramp_cnt;
    logic               ramp_tick;
    logic               ramp_clr;
    logic [PRE_W-1:0]   pre_cnt;
    logic               pre_tick;
    logic [cmd_l-1:0]   pwm_cnt;
    logic               all_faulty;

`ifdef MOTION_SEQ_DWELL_EN
    logic [DWELL_W-1:0] dwell_cnt;
    logic               dwell_clr;
    logic               dwell_done;
    assign dwell_done = (dwell_cnt == DWELL_LAST);
`endif

    assign all_faulty = (fault == 3'b111);
    assign ramp_tick  = (ramp_cnt == RAMP_LAST);
    assign pre_tick   = (pre_cnt == PRE_LAST);
    assign state_o    = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and next-speed/direction logic
    always_comb begin
        state_d  = state_q;
        speed_d  = speed_o;
        dir_d    = dir_o;
        ramp_clr = 1'b0;
`ifdef MOTION_SEQ_DWELL_EN
        dwell_clr = 1'b0;
`endif
        if (all_faulty) begin
            // Emergency stop overrides every other transition.
            state_d  = ST_ESTOP;
            speed_d  = '0;
            ramp_clr = 1'b1;
`ifdef MOTION_SEQ_DWELL_EN
            dwell_clr = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    speed_d = '0;
                    if (speed_cmd_i != '0) begin
                        // Already at zero, so the new direction is safe to take.
                        dir_d    = dir_cmd_i;
                        state_d  = ST_RUN;
                        ramp_clr = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ramp_tick) begin
                        if (dir_cmd_i != dir_o) begin
                            state_d  = ST_BRAKE;
                            ramp_clr = 1'b1;
                        end else if (speed_o == '0 && speed_cmd_i == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            speed_d = step_toward(speed_o, speed_cmd_i);
                        end
                    end
                end
                ST_BRAKE: begin
                    if (ramp_tick) begin
                        if (dir_cmd_i == dir_o) begin
                            // Reversal withdrawn: resume ramping in the old direction.
                            state_d  = ST_RUN;
                            ramp_clr = 1'b1;
                        end else begin
                            speed_d = dec_sat(speed_o);
                            if (speed_d == '0) begin
`ifdef MOTION_SEQ_DWELL_EN
                                state_d   = ST_DWELL;
                                dwell_clr = 1'b1;
`else
                                dir_d = dir_cmd_i;
                                if (speed_cmd_i != '0) begin
                                    state_d  = ST_RUN;
                                    ramp_clr = 1'b1;
                                end else begin
                                    state_d = ST_IDLE;
                                end
`endif
                            end
                        end
                    end
                end
`ifdef MOTION_SEQ_DWELL_EN
                ST_DWELL: begin
                    speed_d = '0;
                    if (dwell_done) begin
                        dir_d = dir_cmd_i;
                        if (speed_cmd_i != '0) begin
                            state_d  = ST_RUN;
                            ramp_clr = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
`endif
                ST_ESTOP: begin
                    speed_d = '0;
                    // Re-arm only once the operator has commanded zero speed.
                    if (speed_cmd_i == '0)
                        state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    speed_d = '0;
                end
            endcase
        end
    end

    // Applied speed, direction and motion flag
    always_ff @(posedge clk) begin
        if (rst) begin
            speed_o <= '0;
            dir_o   <= DEF_DIR;
            moving  <= 1'b0;
        end else begin
            speed_o <= speed_d;
            dir_o   <= dir_d;
            moving  <= (speed_d != '0);
        end
    end

    // Ramp period counter, only advancing while the speed may change
    always_ff @(posedge clk) begin
        if (rst || ramp_clr)
            ramp_cnt <= '0;
        else if (state_q == ST_RUN || state_q == ST_BRAKE)
            ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
        else
            ramp_cnt <= '0;
    end

`ifdef MOTION_SEQ_DWELL_EN
    // Dwell counter, only advancing while parked at zero before a reversal
    always_ff @(posedge clk) begin
        if (rst || dwell_clr)
            dwell_cnt <= '0;
        else if (state_q == ST_DWELL && !dwell_done)
            dwell_cnt <= dwell_cnt + 1'b1;
        else
            dwell_cnt <= '0;
    end
`endif

    // PWM prescaler, duty counter and registered comparator
    always_ff @(posedge clk) begin
        if (rst || all_faulty) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            pwm_o   <= 1'b0;
        end else begin
            pre_cnt <= pre_tick ? '0 : pre_cnt + 1'b1;
            if (pre_tick)
                pwm_cnt <= pwm_cnt + 1'b1;
            pwm_o <= (pwm_cnt < speed_o);
        end
    end

endmodule

// File: tb/tb_motion_sequencer.sv
// =============================================================================
// tb_motion_sequencer
// Table-driven bench for motion_sequencer with ramp_t=4, dwell_t=8,
// pwm_div=1, cmd_l=4. Each record applies inputs, advances a number of clock
// edges and then checks speed, direction, state and the motion flag (and
// optionally the PWM output). PWM duty is checked by hand-written windows.
// =============================================================================
module tb_motion_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] speed_cmd_i;
    logic [3:0] dir_cmd_i;
    logic [2:0] fault;
    logic [3:0] speed_o;
    logic [3:0] dir_o;
    logic       pwm_o;
    logic       moving;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    motion_sequencer #(
        .cmd_l       (4),
        .def_dir_cmd (8),
        .ramp_t      (4),
        .dwell_t     (8),
        .pwm_div     (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .speed_cmd_i (speed_cmd_i),
        .dir_cmd_i   (dir_cmd_i),
        .fault       (fault),
        .speed_o     (speed_o),
        .dir_o       (dir_o),
        .pwm_o       (pwm_o),
        .moving      (moving),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] spd;
        logic [3:0] dir;
        logic [2:0] flt;
        int         n;
        logic [3:0] e_spd;
        logic [3:0] e_dir;
        logic [2:0] e_st;
        logic       chk_pwm;
        logic       e_pwm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] s, input logic [3:0] d,
                       input logic [2:0] f, input int n, input logic [3:0] es,
                       input logic [3:0] ed, input logic [2:0] est,
                       input logic cp, input logic ep);
        vec_t v;
        v.rst = r; v.spd = s; v.dir = d; v.flt = f; v.n = n;
        v.e_spd = es; v.e_dir = ed; v.e_st = est; v.chk_pwm = cp; v.e_pwm = ep;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            rst         = tbl[i].rst;
            speed_cmd_i = tbl[i].spd;
            dir_cmd_i   = tbl[i].dir;
            fault       = tbl[i].flt;
            repeat (tbl[i].n) @(posedge clk);
            #1;
            check($sformatf("row%0d speed", i), 32'(speed_o), 32'(tbl[i].e_spd));
            check($sformatf("row%0d dir", i), 32'(dir_o), 32'(tbl[i].e_dir));
            check($sformatf("row%0d state", i), 32'(state_o), 32'(tbl[i].e_st));
            check($sformatf("row%0d moving", i), 32'(moving), 32'(tbl[i].e_spd != 4'd0));
            if (tbl[i].chk_pwm)
                check($sformatf("row%0d pwm", i), 32'(pwm_o), 32'(tbl[i].e_pwm));
        end
    endtask

    task automatic pwm_window(input string name, input int exp_high);
        int highs;
        highs = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (pwm_o === 1'b1)
                highs++;
        end
        check(name, 32'(highs), 32'(exp_high));
    endtask

    int seg1;
    int seg2;

    initial begin
        rst = 1'b1; speed_cmd_i = 4'd0; dir_cmd_i = 4'd3; fault = 3'b000;

        // Reset and idle: direction comes from the reset default, not dir_cmd_i.
        add(1, 0, 3, 3'b000, 3, 0, 8, 0, 1, 0);
        add(0, 0, 3, 3'b000, 3, 0, 8, 0, 1, 0);
        // Ramp up to 5: RUN entry, first step 4 cycles later, 5 after 20 cycles.
        add(0, 5, 8, 3'b000, 1, 0, 8, 1, 0, 0);
        add(0, 5, 8, 3'b000, 3, 0, 8, 1, 0, 0);
        add(0, 5, 8, 3'b000, 1, 1, 8, 1, 0, 0);
        add(0, 5, 8, 3'b000, 4, 2, 8, 1, 0, 0);
        add(0, 5, 8, 3'b000, 4, 3, 8, 1, 0, 0);
        add(0, 5, 8, 3'b000, 4, 4, 8, 1, 0, 0);
        add(0, 5, 8, 3'b000, 4, 5, 8, 1, 0, 0);
        add(0, 5, 8, 3'b000, 8, 5, 8, 1, 0, 0);
        // Reversal cancelled at speed 3.
        add(0, 5, 2, 3'b000, 3, 5, 8, 1, 0, 0);
        add(0, 5, 2, 3'b000, 1, 5, 8, 2, 0, 0);
        add(0, 5, 2, 3'b000, 4, 4, 8, 2, 0, 0);
        add(0, 5, 2, 3'b000, 4, 3, 8, 2, 0, 0);
        add(0, 5, 8, 3'b000, 4, 3, 8, 1, 0, 0);
        add(0, 5, 8, 3'b000, 4, 4, 8, 1, 0, 0);
        add(0, 5, 8, 3'b000, 4, 5, 8, 1, 0, 0);
        // Full reversal 8 -> 2.
        add(0, 5, 2, 3'b000, 4, 5, 8, 2, 0, 0);
        add(0, 5, 2, 3'b000, 16, 1, 8, 2, 0, 0);
`ifdef MOTION_SEQ_DWELL_EN
        add(0, 5, 2, 3'b000, 4, 0, 8, 3, 0, 0);
        add(0, 5, 2, 3'b000, 7, 0, 8, 3, 0, 0);
        add(0, 5, 2, 3'b000, 1, 0, 2, 1, 0, 0);
        add(0, 5, 2, 3'b000, 20, 5, 2, 1, 0, 0);
`else
        add(0, 5, 2, 3'b000, 4, 0, 2, 1, 0, 0);
        add(0, 5, 2, 3'b000, 4, 1, 2, 1, 0, 0);
        add(0, 5, 2, 3'b000, 16, 5, 2, 1, 0, 0);
`endif
        // Lower the target to 4 (one downward step).
        add(0, 4, 2, 3'b000, 4, 4, 2, 1, 0, 0);
        seg1 = tbl.size();
        // ESTOP at speed 4, held while the command is non-zero, re-armed at zero.
        add(0, 4, 2, 3'b111, 1, 0, 2, 4, 1, 0);
        add(0, 4, 2, 3'b111, 3, 0, 2, 4, 1, 0);
        add(0, 4, 2, 3'b011, 5, 0, 2, 4, 1, 0);
        add(0, 0, 2, 3'b011, 1, 0, 2, 0, 1, 0);
        seg2 = tbl.size();
        // Reset mid-ramp at speed 3.
        add(0, 5, 6, 3'b000, 1, 0, 6, 1, 0, 0);
        add(0, 5, 6, 3'b000, 12, 3, 6, 1, 0, 0);
        add(1, 5, 6, 3'b000, 1, 0, 8, 0, 1, 0);
        add(0, 0, 8, 3'b000, 4, 0, 8, 0, 1, 0);
        // ESTOP beats IDLE -> RUN.
        add(0, 3, 8, 3'b111, 1, 0, 8, 4, 1, 0);
        add(0, 0, 8, 3'b000, 1, 0, 8, 0, 1, 0);

        run_rows(0, seg1);
        pwm_window("pwm duty speed4", 4);
        run_rows(seg1, seg2);
        pwm_window("pwm duty speed0", 0);
        run_rows(seg2, tbl.size());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
